// File: rtl/gcd_operand_feeder.sv
// Operand-pair FIFO and load sequencer for the subtractive GCD engine, with a BUSY watchdog.
// Optional macro GCD_ZERO_GUARD_EN: drop pairs with a zero operand instead of launching them.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | bus parked at 0, waiting for a queued pair
//   S_LOAD_A  | operand A on the bus with eng_start
//   S_LOAD_B  | operand B on the bus, head popped, watchdog cleared
//   S_BUSY    | engine computing; watchdog counting
//   S_RESTART | job finished or aborted; restart pulse follows
module gcd_operand_feeder #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    output logic [WIDTH-1:0] eng_data_o,
    output logic             eng_start_o,
    input  logic             eng_done_i,
    output logic             eng_restart_o,
    output logic             job_done_o,
    output logic             timeout_o,
    output logic             err_zero_o,
    output logic             busy_o
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int WDW = $clog2(TIMEOUT_CYC);

    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYC - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_A  = 3'd1;
    localparam logic [2:0] S_LOAD_B  = 3'd2;
    localparam logic [2:0] S_BUSY    = 3'd3;
    localparam logic [2:0] S_RESTART = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] fifo_a_q [DEPTH];
    logic [WIDTH-1:0] fifo_b_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WDW-1:0]   wd_q, wd_d;
    logic [WIDTH-1:0] eng_data_q, eng_data_d;
    logic             eng_start_q, eng_start_d;
    logic             eng_restart_q, eng_restart_d;
    logic             job_done_q, job_done_d;
    logic             timeout_q, timeout_d;
    logic             err_zero_q, err_zero_d;
    logic [WIDTH-1:0] head_a, head_b;
    logic             push, pop, fifo_empty, head_zero;

    assign in_ready_o = (count_q != CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign push       = in_valid_i && in_ready_o;
    assign head_a     = fifo_a_q[rd_ptr_q];
    assign head_b     = fifo_b_q[rd_ptr_q];

`ifdef GCD_ZERO_GUARD_EN
    assign head_zero = (head_a == '0) || (head_b == '0);
`else
    assign head_zero = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_a_q[wr_ptr_q] <= in_a_i;
            fifo_b_q[wr_ptr_q] <= in_b_i;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Outputs are registered alongside the state, so each pulse is visible in the
    // cycle the FSM enters the state it belongs to; restart trails RESTART by one.
    always_comb begin
        state_d       = state_q;
        wd_d          = wd_q;
        eng_data_d    = eng_data_q;
        eng_start_d   = 1'b0;
        eng_restart_d = (state_q == S_RESTART);
        job_done_d    = 1'b0;
        timeout_d     = 1'b0;
        err_zero_d    = 1'b0;
        pop           = 1'b0;
        case (state_q)
            S_IDLE: begin
                eng_data_d = '0;
                if (!fifo_empty) begin
                    if (head_zero) begin
                        pop        = 1'b1;
                        err_zero_d = 1'b1;
                    end else begin
                        state_d     = S_LOAD_A;
                        eng_data_d  = head_a;
                        eng_start_d = 1'b1;
                    end
                end
            end
            S_LOAD_A: begin
                state_d    = S_LOAD_B;
                eng_data_d = head_b;
            end
            S_LOAD_B: begin
                state_d = S_BUSY;
                pop     = 1'b1;
                wd_d    = '0;
            end
            S_BUSY: begin
                wd_d = wd_q + WDW'(1);
                if (eng_done_i) begin
                    state_d    = S_RESTART;
                    job_done_d = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    state_d   = S_RESTART;
                    timeout_d = 1'b1;
                end
            end
            S_RESTART: begin
                state_d    = S_IDLE;
                eng_data_d = '0;
            end
            default: begin
                state_d    = S_IDLE;
                eng_data_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            wd_q          <= '0;
            eng_data_q    <= '0;
            eng_start_q   <= 1'b0;
            eng_restart_q <= 1'b0;
            job_done_q    <= 1'b0;
            timeout_q     <= 1'b0;
            err_zero_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            wd_q          <= wd_d;
            eng_data_q    <= eng_data_d;
            eng_start_q   <= eng_start_d;
            eng_restart_q <= eng_restart_d;
            job_done_q    <= job_done_d;
            timeout_q     <= timeout_d;
            err_zero_q    <= err_zero_d;
        end
    end

    assign eng_data_o    = eng_data_q;
    assign eng_start_o   = eng_start_q;
    assign eng_restart_o = eng_restart_q;
    assign job_done_o    = job_done_q;
    assign timeout_o     = timeout_q;
    assign err_zero_o    = err_zero_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Directed bench for gcd_operand_feeder with an 8-cycle watchdog.
// Zero-operand expectations follow GCD_ZERO_GUARD_EN when the bench is built with it.
module tb_gcd_operand_feeder;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_a_i, in_b_i;
    logic [WIDTH-1:0] eng_data_o;
    logic             eng_start_o, eng_done_i, eng_restart_o;
    logic             job_done_o, timeout_o, err_zero_o, busy_o;

    int checks = 0;
    int errors = 0;
    int n_timeout = 0;
    int n_restart = 0;
    int n_job_done = 0;
    logic [WIDTH-1:0] a_log[$];
    logic [WIDTH-1:0] b_log[$];
    logic prev_start = 1'b0;

    gcd_operand_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_a_i(in_a_i), .in_b_i(in_b_i),
        .eng_data_o(eng_data_o), .eng_start_o(eng_start_o),
        .eng_done_i(eng_done_i), .eng_restart_o(eng_restart_o),
        .job_done_o(job_done_o), .timeout_o(timeout_o),
        .err_zero_o(err_zero_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_start = 1'b0;
        end else begin
            if (prev_start) b_log.push_back(eng_data_o);
            prev_start = eng_start_o;
            if (eng_start_o) a_log.push_back(eng_data_o);
            if (timeout_o) n_timeout++;
            if (eng_restart_o) n_restart++;
            if (job_done_o) n_job_done++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid_i = 1'b1; in_a_i = a; in_b_i = b;
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!eng_start_o && n < 50) begin tick(); n++; end
        checks++;
        if (eng_start_o !== 1'b1) begin
            errors++;
            $display("FAIL %s: eng_start got %b expected 1 within 50 cycles", tag, eng_start_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; in_valid_i = 1'b0; in_a_i = '0; in_b_i = '0; eng_done_i = 1'b0;
        tick(); tick();
        checks++;
        if ({busy_o, in_ready_o, eng_start_o, eng_restart_o, job_done_o, timeout_o, err_zero_o} !== 7'b0100000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0100000",
                     {busy_o, in_ready_o, eng_start_o, eng_restart_o, job_done_o, timeout_o, err_zero_o});
        end
        checks++;
        if (eng_data_o !== '0) begin errors++; $display("FAIL reset_data: got %0d expected 0", eng_data_o); end
        rst_i = 1'b0;
        tick(); tick();
        checks++;
        if ({busy_o, eng_start_o} !== 2'b00) begin
            errors++; $display("FAIL idle_after_reset: busy,start got %b expected 00", {busy_o, eng_start_o});
        end
    endtask

    task automatic test_single_job();
        push_pair(16'd48, 16'd18);
        checks++;
        if (eng_start_o !== 1'b0) begin errors++; $display("FAIL launch_latency: start got %b expected 0 one cycle after push", eng_start_o); end
        tick();
        checks++;
        if ({eng_start_o, busy_o} !== 2'b11 || eng_data_o !== 16'd48) begin
            errors++; $display("FAIL load_a: start,busy got %b data %0d expected 11 data 48", {eng_start_o, busy_o}, eng_data_o);
        end
        tick();
        checks++;
        if (eng_start_o !== 1'b0 || eng_data_o !== 16'd18) begin
            errors++; $display("FAIL load_b: start got %b data %0d expected 0 data 18", eng_start_o, eng_data_o);
        end
        tick(); tick(); tick();
        checks++;
        if (job_done_o !== 1'b0 || eng_data_o !== 16'd18) begin
            errors++; $display("FAIL busy_hold: job_done got %b data %0d expected 0 data 18", job_done_o, eng_data_o);
        end
        eng_done_i = 1'b1;
        tick();
        checks++;
        if ({job_done_o, timeout_o, eng_restart_o, busy_o} !== 4'b1001) begin
            errors++; $display("FAIL job_done: done,tmo,restart,busy got %b expected 1001", {job_done_o, timeout_o, eng_restart_o, busy_o});
        end
        tick();
        checks++;
        if ({eng_restart_o, job_done_o, busy_o} !== 3'b100 || eng_data_o !== '0) begin
            errors++; $display("FAIL restart: restart,done,busy got %b data %0d expected 100 data 0",
                               {eng_restart_o, job_done_o, busy_o}, eng_data_o);
        end
        eng_done_i = 1'b0;
        tick();
        checks++;
        if ({eng_restart_o, eng_start_o} !== 2'b00) begin
            errors++; $display("FAIL restart_pulse_width: restart,start got %b expected 00", {eng_restart_o, eng_start_o});
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] pa [5] = '{16'd12, 16'd35, 16'd9, 16'd100, 16'd21};
        logic [WIDTH-1:0] pb [5] = '{16'd8, 16'd14, 16'd6, 16'd75, 16'd49};
        int base = n_timeout;
        int n = 0;
        a_log.delete(); b_log.delete();
        for (int k = 0; k < 5; k++) begin
            in_valid_i = 1'b1; in_a_i = pa[k]; in_b_i = pb[k];
            tick();
        end
        checks++;
        if (in_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: in_ready got %b expected 0", in_ready_o); end
        in_a_i = 16'd99; in_b_i = 16'd99;
        tick(); tick(); tick();
        in_valid_i = 1'b0;
        checks++;
        if (in_ready_o !== 1'b0) begin errors++; $display("FAIL full_hold: in_ready got %b expected 0", in_ready_o); end
        while (!in_ready_o && n < 40) begin tick(); n++; end
        checks++;
        if (in_ready_o !== 1'b1 || a_log.size() != 2) begin
            errors++; $display("FAIL ready_after_pop: in_ready got %b launches %0d expected 1 and 2", in_ready_o, a_log.size());
        end
        n = 0;
        while (n_timeout < base + 5 && n < 150) begin tick(); n++; end
        tick(); tick();
        checks++;
        if (a_log.size() != 5 || b_log.size() != 5) begin
            errors++; $display("FAIL launch_count: got %0d/%0d launches expected 5", a_log.size(), b_log.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (a_log[k] !== pa[k] || b_log[k] !== pb[k]) begin
                    errors++; $display("FAIL fifo_order[%0d]: got (%0d,%0d) expected (%0d,%0d)", k, a_log[k], b_log[k], pa[k], pb[k]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        in_valid_i = 1'b1; in_a_i = 16'd20; in_b_i = 16'd5;
        tick();
        in_a_i = 16'd27; in_b_i = 16'd9;
        tick();
        in_valid_i = 1'b0;
        wait_start("timeout_launch");
        checks++;
        if (eng_data_o !== 16'd20) begin errors++; $display("FAIL timeout_a: data got %0d expected 20", eng_data_o); end
        tick(); tick();
        for (int i = 1; i < TMO; i++) begin
            tick();
            checks++;
            if (timeout_o !== 1'b0) begin errors++; $display("FAIL timeout_early[%0d]: timeout got %b expected 0", i, timeout_o); end
        end
        tick();
        checks++;
        if ({timeout_o, job_done_o, eng_restart_o} !== 3'b100) begin
            errors++; $display("FAIL timeout_pulse: tmo,done,restart got %b expected 100", {timeout_o, job_done_o, eng_restart_o});
        end
        tick();
        checks++;
        if ({eng_restart_o, timeout_o} !== 2'b10) begin
            errors++; $display("FAIL timeout_restart: restart,tmo got %b expected 10", {eng_restart_o, timeout_o});
        end
        tick();
        checks++;
        if (eng_start_o !== 1'b1 || eng_data_o !== 16'd27) begin
            errors++; $display("FAIL next_launch: start got %b data %0d expected 1 data 27", eng_start_o, eng_data_o);
        end
        tick(); tick();
        eng_done_i = 1'b1;
        tick();
        checks++;
        if (job_done_o !== 1'b1) begin errors++; $display("FAIL done_first_busy: job_done got %b expected 1", job_done_o); end
        eng_done_i = 1'b0;
        tick(); tick();
    endtask

    task automatic test_done_at_expiry();
        push_pair(16'd30, 16'd12);
        wait_start("expiry_launch");
        tick(); tick();
        for (int i = 1; i < TMO; i++) tick();
        eng_done_i = 1'b1;
        tick();
        checks++;
        if ({job_done_o, timeout_o} !== 2'b10) begin
            errors++; $display("FAIL done_wins: done,tmo got %b expected 10", {job_done_o, timeout_o});
        end
        eng_done_i = 1'b0;
        tick(); tick();
    endtask

    task automatic test_zero_operand();
        int na = a_log.size();
        int base = n_timeout;
        int n = 0;
        push_pair(16'd0, 16'd7);
        tick();
`ifdef GCD_ZERO_GUARD_EN
        checks++;
        if ({err_zero_o, eng_start_o, busy_o} !== 3'b100) begin
            errors++; $display("FAIL zero_guard: err,start,busy got %b expected 100", {err_zero_o, eng_start_o, busy_o});
        end
        tick();
        checks++;
        if (err_zero_o !== 1'b0) begin errors++; $display("FAIL zero_pulse_width: err_zero got %b expected 0", err_zero_o); end
        tick(); tick(); tick();
        checks++;
        if (a_log.size() != na) begin errors++; $display("FAIL zero_no_launch: launches got %0d expected %0d", a_log.size(), na); end
        push_pair(16'd14, 16'd21);
        tick();
        checks++;
        if (eng_start_o !== 1'b1 || eng_data_o !== 16'd14) begin
            errors++; $display("FAIL zero_fifo_empty: start got %b data %0d expected 1 data 14", eng_start_o, eng_data_o);
        end
        tick(); tick();
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        tick(); tick();
`else
        checks++;
        if ({eng_start_o, err_zero_o} !== 2'b10 || eng_data_o !== '0) begin
            errors++; $display("FAIL zero_launch: start,err got %b data %0d expected 10 data 0", {eng_start_o, err_zero_o}, eng_data_o);
        end
        tick();
        checks++;
        if (eng_data_o !== 16'd7) begin errors++; $display("FAIL zero_b: data got %0d expected 7", eng_data_o); end
        while (n_timeout == base && n < 30) begin tick(); n++; end
        checks++;
        if (n_timeout != base + 1) begin
            errors++; $display("FAIL zero_timeout: timeouts got %0d expected %0d", n_timeout - base, 1);
        end
        tick(); tick();
`endif
    endtask

    task automatic test_reset_mid_busy();
        int na;
        int nr;
        push_pair(16'd40, 16'd16);
        wait_start("reset_launch");
        tick(); tick();
        in_valid_i = 1'b1; in_a_i = 16'd1; in_b_i = 16'd2;
        tick();
        in_a_i = 16'd3; in_b_i = 16'd4;
        tick();
        in_valid_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: busy got %b expected 1", busy_o); end
        na = a_log.size();
        nr = n_restart;
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({busy_o, in_ready_o, eng_start_o, eng_restart_o, job_done_o, timeout_o, err_zero_o} !== 7'b0100000
            || eng_data_o !== '0) begin
            errors++; $display("FAIL async_reset: flags got %b data %0d expected 0100000 data 0",
                {busy_o, in_ready_o, eng_start_o, eng_restart_o, job_done_o, timeout_o, err_zero_o}, eng_data_o);
        end
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (a_log.size() != na || n_restart != nr || busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_flush: launches +%0d restarts +%0d busy %b expected +0 +0 0",
                               a_log.size() - na, n_restart - nr, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_back_to_back();
        test_timeout();
        test_done_at_expiry();
        test_zero_operand();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
